// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard / mult-div stall controller
module pipe_ctrl #(
  parameter int MD_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        md_req,
  input  logic        stall_cnt_clr,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        md_start,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

  // start cycle holds ID once, busy cycles cover the remaining MD_LAT-1
  localparam logic [5:0] MD_LOAD = 6'(MD_LAT - 2);

  state_t      state;
  logic [5:0]  md_cnt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        lu;

  assign id_rs = id_inst[25:21];
  assign id_rt = id_inst[20:16];

  // load-use hazard between EX load and ID source registers
  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (ex_rt == id_rt)) &&
              (id_inst != 32'd0);

  // control outputs decoded from state and inputs; quiet while in reset
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    md_start     = 1'b0;
    busy         = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (md_req) begin
            md_start     = 1'b1;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          busy         = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // state and mult/div hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= 6'd0;
    end else begin
      case (state)
        RUN: begin
          if (!ex_branch_taken && !lu && md_req) begin
            state  <= MD_BUSY;
            md_cnt <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (md_cnt == 6'd0) begin
            state <= MD_DONE;
          end else begin
            md_cnt <= md_cnt - 6'd1;
          end
        end
        MD_DONE: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // saturating count of PC-frozen cycles; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= 16'd0;
    end else if (!pc_en && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int LAT = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_inst;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        md_req;
  logic        stall_cnt_clr;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        md_start;
  logic        busy;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // reference model: remaining busy cycles, pending done cycle, stall count
  int m_hold = 0;
  bit m_done = 0;
  int m_cnt  = 0;

  pipe_ctrl #(.MD_LAT(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_inst         (id_inst),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .md_req          (md_req),
    .stall_cnt_clr   (stall_cnt_clr),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .md_start        (md_start),
    .busy            (busy),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0;
    m_done = 0;
    m_cnt  = 0;
  endtask

  // one clock cycle: drive, check outputs against model, advance model
  task automatic step(input logic [31:0] inst, input logic mr, input logic [4:0] rt,
                      input logic bt, input logic md, input logic clr);
    bit e_pc, e_ifen, e_fl, e_bub, e_ms, e_busy, lu;
    @(negedge clk);
    id_inst = inst; ex_mem_read = mr; ex_rt = rt;
    ex_branch_taken = bt; md_req = md; stall_cnt_clr = clr;
    #1;
    lu = mr && (rt != 0) && (rt == inst[25:21] || rt == inst[20:16]) && (inst != 0);
    e_pc = 1; e_ifen = 1; e_fl = 0; e_bub = 0; e_ms = 0; e_busy = 0;
    if (m_hold > 0) begin
      e_pc = 0; e_ifen = 0; e_bub = 1; e_busy = 1;
    end else if (m_done) begin
      // instruction leaves ID, nothing else happens
    end else if (bt) begin
      e_fl = 1; e_bub = 1;
    end else if (lu) begin
      e_pc = 0; e_ifen = 0; e_bub = 1;
    end else if (md) begin
      e_ms = 1; e_pc = 0; e_ifen = 0; e_bub = 1;
    end
    chk("pc_en", pc_en, e_pc);
    chk("if_id_en", if_id_en, e_ifen);
    chk("if_id_flush", if_id_flush, e_fl);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("md_start", md_start, e_ms);
    chk("busy", busy, e_busy);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (e_ms) begin
      m_hold = LAT - 1;
    end
    if (clr) m_cnt = 0;
    else if (!e_pc && m_cnt < 16'hFFFF) m_cnt++;
    @(posedge clk);
  endtask

  localparam logic [31:0] INST_RS5 = 32'h00A0_0000;
  localparam logic [31:0] INST_RT5 = 32'h0005_1234;
  localparam logic [31:0] INST_RS0 = 32'h0003_0000;

  initial begin
    int base;
    int rem;
    logic [31:0] ri;
    rst_n = 1'b0; id_inst = 32'd0; ex_mem_read = 0; ex_rt = 0;
    ex_branch_taken = 0; md_req = 1; stall_cnt_clr = 0;
    #12;
    chk("rst_pc_en", pc_en, 1);
    chk("rst_if_id_en", if_id_en, 1);
    chk("rst_md_start", md_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    md_req = 0;
    rst_n = 1'b1;
    model_reset();

    // load-use on rs stalls one cycle
    step(INST_RS5, 1, 5'd5, 0, 0, 0);
    #1 chk("lu_cnt", stall_cnt, 1);
    step(INST_RT5, 1, 5'd5, 0, 0, 0);
    // no-hazard cases
    step(INST_RS0, 1, 5'd0, 0, 0, 0);
    step(32'd0, 1, 5'd0, 0, 0, 0);
    step(32'd0, 1, 5'd5, 0, 0, 0);
    step(INST_RS5, 0, 5'd5, 0, 0, 0);
    // branch beats load-use and md_req
    step(INST_RS5, 1, 5'd5, 1, 1, 0);
    step(INST_RS5, 1, 5'd5, 1, 0, 0);
    #1 chk("br_cnt", stall_cnt, 2);

    // mult/div with md_req held, then back-to-back start
    base = m_cnt;
    for (int i = 0; i < LAT + 1; i++) step(32'h0000_0018, 0, 5'd0, 0, 1, 0);
    #1 chk("md_stall8", stall_cnt, base + LAT);
    step(32'h0000_0018, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < LAT; i++) step(32'h0000_0018, 0, 5'd0, 0, 0, 0);

    // reset during the third busy cycle aborts the sequence
    step(32'h0000_0018, 0, 5'd0, 0, 1, 0);
    step(32'h0000_0018, 0, 5'd0, 0, 1, 0);
    step(32'h0000_0018, 0, 5'd0, 0, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_pc_en", pc_en, 1);
    chk("abort_md_start", md_start, 0);
    chk("abort_cnt", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    md_req = 0;
    rst_n = 1'b1;
    step(32'h0000_0018, 0, 5'd0, 0, 0, 0);
    step(32'h0000_0018, 0, 5'd0, 0, 0, 0);

    // clear wins over a stall
    step(INST_RS5, 1, 5'd5, 0, 0, 0);
    step(INST_RS5, 1, 5'd5, 0, 0, 1);
    #1 chk("clr_stall", stall_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      ri = $urandom;
      ri[25:21] = 5'($urandom_range(0, 7));
      ri[20:16] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ri = 32'd0;
      step(ri, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 49) == 0));
    end

    // drive counter up to 16'hFFFE with continuous load-use, then saturate
    rem = 16'hFFFE - m_cnt;
    if (m_hold > 0 || m_done) rem = 0;
    for (int i = 0; i < LAT + 1; i++) step(32'd0, 0, 5'd0, 0, 0, 0);
    rem = 16'hFFFE - m_cnt;
    for (int i = 0; i < rem; i++) step(INST_RS5, 1, 5'd5, 0, 0, 0);
    #1 chk("sat_pre", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) step(INST_RS5, 1, 5'd5, 0, 0, 0);
    #1 chk("sat_hold", stall_cnt, 16'hFFFF);
    step(INST_RS5, 1, 5'd5, 0, 0, 1);
    #1 chk("sat_clr", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MD_LAT, default 8, mult/div latency in cycles; legal range 2..63.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 id_inst  input  32  instruction in ID; rs=[25:21], rt=[20:16]; 32'd0 = nop.
REQ-005 ex_mem_read  input  1  instruction in EX is a load.
REQ-006 ex_rt  input  5  destination rt of EX instruction.
REQ-007 ex_branch_taken  input  1  branch in EX resolved taken.
REQ-008 md_req  input  1  ID instruction is mult/div.
REQ-009 stall_cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-010 pc_en  output  1  PC write enable.
REQ-011 if_id_en  output  1  IF/ID register write enable.
REQ-012 if_id_flush  output  1  zero IF/ID register.
REQ-013 id_ex_bubble  output  1  load nop into ID/EX.
REQ-014 md_start  output  1  one-cycle start pulse to mult/div unit.
REQ-015 busy  output  1  high while state is MD_BUSY.
REQ-016 stall_cnt  output  16  count of cycles with pc_en=0.

Function
REQ-017 Outputs SHALL be combinational from state and inputs; state, counter and stall_cnt registered on clk.
REQ-018 States SHALL be RUN, MD_BUSY, MD_DONE.
REQ-019 Load-use hazard lu SHALL be: ex_mem_read & ex_rt!=0 & (ex_rt==rs | ex_rt==rt) & id_inst!=0.
REQ-020 Defaults: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=0, md_start=0.
REQ-021 RUN priority 1, ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_en=1; lu and md_req ignored; stay RUN.
REQ-022 RUN priority 2, lu: pc_en=0, if_id_en=0, id_ex_bubble=1; stay RUN; md_req ignored this cycle.
REQ-023 RUN priority 3, md_req: md_start=1, pc_en=0, if_id_en=0, id_ex_bubble=1; counter loads MD_LAT-2; next state MD_BUSY.
REQ-024 MD_BUSY: pc_en=0, if_id_en=0, id_ex_bubble=1, busy=1; counter decrements; at counter==0 next state MD_DONE.
REQ-025 MD_DONE: default outputs (instruction advances to EX); md_req, lu, ex_branch_taken ignored; next state RUN.
REQ-026 Total hold of the mult/div instruction in ID SHALL be exactly MD_LAT cycles (1 start + MD_LAT-1 busy).
REQ-027 Counter SHALL be 6 bits, no wrap below 0.
REQ-028 stall_cnt SHALL increment by 1 each cycle pc_en=0, saturate at 16'hFFFF; stall_cnt_clr wins over increment, result 0.
REQ-029 Back-to-back md_req after MD_DONE SHALL start a new sequence in the following RUN cycle.

Reset
REQ-030 rst_n=0 SHALL force state RUN, counter 0, stall_cnt 0 immediately, independent of clk.
REQ-031 During reset outputs SHALL be pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=0, md_start=0, busy=0.
REQ-032 Reset asserted in MD_BUSY SHALL abort the sequence; no md_start after release unless md_req is sampled in RUN.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rt=5, id_inst rs=5 -> one cycle pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt 0->1.
REQ-034 ex_rt=0 with rs=0, ex_mem_read=1; or id_inst=0 -> no stall.
REQ-035 Branch and lu same cycle -> if_id_flush=1, id_ex_bubble=1, pc_en=1; stall_cnt unchanged.
REQ-036 MD_LAT=8, md_req held -> md_start one cycle; busy 7 cycles; pc_en=0 for 8 cycles; MD_DONE 1 cycle with pc_en=1; stall_cnt +8.
REQ-037 rst_n low at 3rd busy cycle -> busy=0, pc_en=1 asynchronously; stall_cnt=0.
REQ-038 Force stall_cnt=16'hFFFE, 3 stall cycles -> holds 16'hFFFF; stall_cnt_clr plus stall -> 0.
